// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter: two FIFO-fed producers share the regfile write port, r15 is routed to pc_we.
// Head granted the cycle after enqueue into registered outputs; a full port FIFO drops its ready until its head retires.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [3:0]    i_addr,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_empty,
  output logic          o_full,
  output logic [3:0]    o_head_addr,
  output logic [DW-1:0] o_head_data,
  output logic [15:0]   o_addr_mask
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [3:0]    r_addr_mem [DEPTH];
  logic [DW-1:0] r_data_mem [DEPTH];
  logic [AW:0]   w_count;
  logic [AW-1:0] w_off;

  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head_addr = r_addr_mem[r_rd_ptr[AW-1:0]];
  assign o_head_data = r_data_mem[r_rd_ptr[AW-1:0]];
  assign w_count     = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_addr_mem[r_wr_ptr[AW-1:0]] <= i_addr;
      r_data_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    o_addr_mask = '0;
    w_off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off = AW'(i) - r_rd_ptr[AW-1:0];
      if ({1'b0, w_off} < w_count) o_addr_mask[r_addr_mem[i]] = 1'b1;
    end
  end
endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [3:0]    a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [3:0]    b_addr,
  input  logic [DW-1:0] b_data,
  output logic          we3,
  output logic [3:0]    a3,
  output logic [DW-1:0] wd3,
  output logic          pc_we,
  output logic [DW-1:0] pc_wd,
  output logic [15:0]   pending,
  output logic          order_err
);
  logic          w_a_push, w_b_push, w_a_empty, w_b_empty, w_a_full, w_b_full;
  logic          w_grant_a, w_grant_b;
  logic [3:0]    w_a_head_addr, w_b_head_addr, w_sel_addr;
  logic [DW-1:0] w_a_head_data, w_b_head_data, w_sel_data;
  logic [15:0]   w_a_mask, w_b_mask;
  logic          r_last_b, r_we3, r_pc_we, r_order_err;
  logic [3:0]    r_a3;
  logic [DW-1:0] r_wd3, r_pc_wd;

  assign a_ready  = !w_a_full && reset;
  assign b_ready  = !w_b_full && reset;
  assign w_a_push = a_valid && a_ready;
  assign w_b_push = b_valid && b_ready;

  wb_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo_a (
    .i_clk(clk), .i_rst_n(reset), .i_push(w_a_push), .i_addr(a_addr), .i_data(a_data),
    .i_pop(w_grant_a), .o_empty(w_a_empty), .o_full(w_a_full),
    .o_head_addr(w_a_head_addr), .o_head_data(w_a_head_data), .o_addr_mask(w_a_mask)
  );

  wb_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo_b (
    .i_clk(clk), .i_rst_n(reset), .i_push(w_b_push), .i_addr(b_addr), .i_data(b_data),
    .i_pop(w_grant_b), .o_empty(w_b_empty), .o_full(w_b_full),
    .o_head_addr(w_b_head_addr), .o_head_data(w_b_head_data), .o_addr_mask(w_b_mask)
  );

  // On contention the port that did not win last time goes first.
  always_comb begin
    w_grant_a  = !w_a_empty && (w_b_empty || r_last_b);
    w_grant_b  = !w_b_empty && (w_a_empty || !r_last_b);
    w_sel_addr = w_grant_a ? w_a_head_addr : w_b_head_addr;
    w_sel_data = w_grant_a ? w_a_head_data : w_b_head_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_b    <= 1'b1;
      r_we3       <= 1'b0;
      r_a3        <= '0;
      r_wd3       <= '0;
      r_pc_we     <= 1'b0;
      r_pc_wd     <= '0;
      r_order_err <= 1'b0;
    end else begin
      r_we3   <= 1'b0;
      r_pc_we <= 1'b0;
      if (w_grant_a || w_grant_b) begin
        r_last_b <= w_grant_b;
        if (w_sel_addr == 4'd15) begin
          r_pc_we <= 1'b1;
          r_pc_wd <= w_sel_data;
          r_a3    <= '0;
        end else begin
          r_we3 <= 1'b1;
          r_a3  <= w_sel_addr;
          r_wd3 <= w_sel_data;
        end
      end
      if (w_a_push && w_b_push && (a_addr == b_addr)) r_order_err <= 1'b1;
    end
  end

  always_comb begin
    pending = w_a_mask | w_b_mask;
    if (r_we3)   pending[r_a3] = 1'b1;
    if (r_pc_we) pending[15]   = 1'b1;
  end

  assign we3       = r_we3;
  assign a3        = r_a3;
  assign wd3       = r_wd3;
  assign pc_we     = r_pc_we;
  assign pc_wd     = r_pc_wd;
  assign order_err = r_order_err;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (DEPTH=2): vector table plus contention, conflict and reset sequences.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [3:0]    a_addr, b_addr, a3;
  logic [DW-1:0] a_data, b_data, wd3, pc_wd;
  logic          we3, pc_we, order_err;
  logic [15:0]   pending;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.DEPTH(2), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we3(we3), .a3(a3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd),
    .pending(pending), .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        av;
    logic [3:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [3:0]  ba;
    logic [31:0] bd;
    logic        we3;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic [15:0] pend;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [3:0] ba, input logic [31:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
      step();
      check($sformatf("row%0d_we3", i),     32'(we3),       32'(vecs[i].we3));
      check($sformatf("row%0d_a3", i),      32'(a3),        32'(vecs[i].a3));
      check($sformatf("row%0d_wd3", i),     wd3,            vecs[i].wd3);
      check($sformatf("row%0d_pc_we", i),   32'(pc_we),     32'(vecs[i].pc_we));
      check($sformatf("row%0d_pc_wd", i),   pc_wd,          vecs[i].pc_wd);
      check($sformatf("row%0d_pending", i), 32'(pending),   32'(vecs[i].pend));
      check($sformatf("row%0d_ready", i),   32'({a_ready, b_ready}), 32'h3);
      check($sformatf("row%0d_order_err", i), 32'(order_err), 32'h0);
    end
  endtask

  task automatic run_contention();
    logic [3:0] ea [8];
    int ai, bi, nw, first_cyc, last_cyc, a_stall, b_stall;
    logic a_acc, b_acc;
    ea = '{4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd8};
    ai = 0; bi = 0; nw = 0; first_cyc = -1; last_cyc = -1; a_stall = 0; b_stall = 0;
    for (int cyc = 0; cyc < 40 && nw < 8; cyc++) begin
      @(negedge clk);
      drive(ai < 4, 4'(ai + 1), 32'h100 + 32'(ai + 1), bi < 4, 4'(bi + 5), 32'h200 + 32'(bi + 5));
      a_acc = a_valid && a_ready;
      b_acc = b_valid && b_ready;
      if (a_valid && !a_ready) a_stall++;
      if (b_valid && !b_ready) b_stall++;
      step();
      if (a_acc) ai++;
      if (b_acc) bi++;
      if (we3) begin
        if (nw < 8) begin
          check($sformatf("cont_a3_%0d", nw), 32'(a3), 32'(ea[nw]));
          check($sformatf("cont_wd3_%0d", nw), wd3,
                (ea[nw] < 4'd5) ? 32'h100 + 32'(ea[nw]) : 32'h200 + 32'(ea[nw]));
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nw++;
      end
    end
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    check("cont_write_count", nw, 8);
    check("cont_gapless", last_cyc - first_cyc, 7);
    check("cont_a_stalls", a_stall, 1);
    check("cont_b_stalls", b_stall, 2);
  endtask

  task automatic run_conflict();
    @(negedge clk);
    drive(1'b1, 4'd7, 32'hA7, 1'b1, 4'd7, 32'hB7);
    step();
    check("conf_order_err", 32'(order_err), 32'h1);
    check("conf_pending_q", 32'(pending), 32'h0080);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step();
    check("conf_first_we3", 32'(we3), 32'h1);
    check("conf_first_a3", 32'(a3), 32'h7);
    check("conf_first_wd3", wd3, 32'hA7);
    check("conf_pending_mid", 32'(pending), 32'h0080);
    step();
    check("conf_second_we3", 32'(we3), 32'h1);
    check("conf_second_wd3", wd3, 32'hB7);
    step();
    check("conf_idle_we3", 32'(we3), 32'h0);
    check("conf_pending_clr", 32'(pending), 32'h0);
    check("conf_sticky", 32'(order_err), 32'h1);
  endtask

  task automatic run_reset_mid();
    int stale;
    @(negedge clk);
    drive(1'b1, 4'd10, 32'h10A, 1'b1, 4'd11, 32'h10B);
    step();
    @(negedge clk);
    drive(1'b1, 4'd12, 32'h10C, 1'b1, 4'd13, 32'h10D);
    step();
    check("rst_pending_before", 32'(pending), 32'h3C00);
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    reset = 1'b0;
    #1;
    check("rst_ready_low", 32'({a_ready, b_ready}), 32'h0);
    step();
    check("rst_we3", 32'(we3), 32'h0);
    check("rst_pc_we", 32'(pc_we), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_a3_wd3", 32'(a3) | wd3 | pc_wd, 32'h0);
    check("rst_order_err", 32'(order_err), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (we3 || pc_we || (pending != 16'h0)) stale++;
    end
    check("rst_no_stale", stale, 0);
    check("rst_ready_back", 32'({a_ready, b_ready}), 32'h3);
    @(negedge clk);
    drive(1'b1, 4'd1, 32'h51, 1'b1, 4'd2, 32'h52);
    step();
    @(negedge clk);
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step();
    check("rst_rr_first_a3", 32'(a3), 32'h1);
    step();
    check("rst_rr_second_a3", 32'(a3), 32'h2);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'd3,  32'h1234, 1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,    1'b0, 32'h0,  16'h0008};
    vecs[1]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0, 32'h0,  1'b1, 4'd3, 32'h1234, 1'b0, 32'h0,  16'h0008};
    vecs[2]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0, 32'h0,  1'b0, 4'd3, 32'h1234, 1'b0, 32'h0,  16'h0000};
    vecs[3]  = '{1'b1, 4'd15, 32'h80,   1'b0, 4'd0, 32'h0,  1'b0, 4'd3, 32'h1234, 1'b0, 32'h0,  16'h8000};
    vecs[4]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h1234, 1'b1, 32'h80, 16'h8000};
    vecs[5]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h1234, 1'b0, 32'h80, 16'h0000};
    vecs[6]  = '{1'b0, 4'd0,  32'h0,    1'b1, 4'd9, 32'hB9, 1'b0, 4'd0, 32'h1234, 1'b0, 32'h80, 16'h0200};
    vecs[7]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0, 32'h0,  1'b1, 4'd9, 32'hB9,   1'b0, 32'h80, 16'h0200};
    vecs[8]  = '{1'b1, 4'd2,  32'h22,   1'b1, 4'd4, 32'h44, 1'b0, 4'd9, 32'hB9,   1'b0, 32'h80, 16'h0014};
    vecs[9]  = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0, 32'h0,  1'b1, 4'd2, 32'h22,   1'b0, 32'h80, 16'h0014};
    vecs[10] = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0, 32'h0,  1'b1, 4'd4, 32'h44,   1'b0, 32'h80, 16'h0010};
    vecs[11] = '{1'b0, 4'd0,  32'h0,    1'b0, 4'd0, 32'h0,  1'b0, 4'd4, 32'h44,   1'b0, 32'h80, 16'h0000};

    reset = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step();
    step();
    check("init_we3", 32'(we3), 32'h0);
    check("init_pc_we", 32'(pc_we), 32'h0);
    check("init_outputs", 32'(a3) | wd3 | pc_wd, 32'h0);
    check("init_pending", 32'(pending), 32'h0);
    check("init_ready", 32'({a_ready, b_ready}), 32'h0);
    check("init_order_err", 32'(order_err), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    run_table();
    run_contention();
    run_conflict();
    run_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
